univ_shift_reg: RTL

Parametrised universal shift register: successor to the single-direction-bit serial shifter. Adds rotate, arithmetic right shift, parallel load and clear modes. Adds a multi-cycle burst command that shifts by a programmed amount under a start/busy/done handshake. Used as the shift/rotate datapath element wherever a register must be moved by N positions without per-cycle control from the host logic.

---
 rtl/univ_shift_reg_if.sv | 28 ++
 rtl/univ_shift_reg.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle for univ_shift_reg: host-side step/burst controls
// and the registered shift-register outputs.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic             en;
    logic [2:0]       mode;
    logic             sin_lsb;
    logic             sin_msb;
    logic [WIDTH-1:0] pdata;
    logic             start;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] out;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, sin_lsb, sin_msb, pdata, start, amt,
        input  out, sout, busy, done
    );

    modport slave (
        input  en, mode, sin_lsb, sin_msb, pdata, start, amt,
        output out, sout, busy, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: single steps under en, or a multi-cycle burst of
// amt steps under a start/busy/done handshake.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input logic            clk,
    input logic            rst,
    univ_shift_reg_if.slave bus
);

    typedef enum logic [2:0] {
        M_HOLD  = 3'b000,
        M_SHL   = 3'b001,
        M_SHR   = 3'b010,
        M_ROL   = 3'b011,
        M_ROR   = 3'b100,
        M_ASR   = 3'b101,
        M_LOAD  = 3'b110,
        M_CLEAR = 3'b111
    } mode_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    mode_t            run_mode_q, run_mode_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sout_q, sout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    mode_t            in_mode;
    mode_t            step_mode;
    logic [WIDTH-1:0] step_data;
    logic             step_sout;
    logic             do_step;
    logic             in_is_shift;

    assign in_mode     = mode_t'(bus.mode);
    assign in_is_shift = in_mode inside {M_SHL, M_SHR, M_ROL, M_ROR, M_ASR};
    // A burst keeps stepping with the mode captured at start, whatever the host drives.
    assign step_mode   = (state_q == S_RUN) ? run_mode_q : in_mode;

    // One step of the selected operation applied to the current contents.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        step_data = data_q;
        step_sout = sout_q;
        case (step_mode)
            M_SHL: begin
                step_data = {data_q[WIDTH-2:0], bus.sin_lsb};
                step_sout = data_q[WIDTH-1];
            end
            M_SHR: begin
                step_data = {bus.sin_msb, data_q[WIDTH-1:1]};
                step_sout = data_q[0];
            end
            M_ROL: begin
                step_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                step_sout = data_q[WIDTH-1];
            end
            M_ROR: begin
                step_data = {data_q[0], data_q[WIDTH-1:1]};
                step_sout = data_q[0];
            end
            M_ASR: begin
                step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                step_sout = data_q[0];
            end
            M_LOAD:  step_data = bus.pdata;
            M_CLEAR: step_data = '0;
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        run_mode_d = run_mode_q;
        cnt_d      = cnt_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        do_step    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (!in_is_shift) begin
                        do_step = 1'b1;
                        done_d  = 1'b1;
                    end else if (bus.amt == '0) begin
                        done_d = 1'b1;
                    end else if (bus.amt == AMT_W'(1)) begin
                        do_step = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        // First step happens on the accepting edge, so amt-1 remain.
                        do_step    = 1'b1;
                        run_mode_d = in_mode;
                        cnt_d      = bus.amt - AMT_W'(1);
                        state_d    = S_RUN;
                        busy_d     = 1'b1;
                    end
                end else if (bus.en) begin
                    do_step = 1'b1;
                end
            end
            S_RUN: begin
                do_step = 1'b1;
                cnt_d   = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        data_d = do_step ? step_data : data_q;
        sout_d = do_step ? step_sout : sout_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            run_mode_q <= M_HOLD;
            cnt_q      <= '0;
            data_q     <= '0;
            sout_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q    <= state_d;
            run_mode_q <= run_mode_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            sout_q     <= sout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.out  = data_q;
    assign bus.sout = sout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
